set_bank_lockable: RTL and testbench



---
 rtl/set_bank_lockable.sv | 129 ++++++++++++
 tb/tb_set_bank_lockable.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_bank_lockable.sv
// Lockable slow-path settings register plus slow-access timeout engine; data arrives on A, no data bus.
// Writes commit one cycle after the registered strobe edge; no backpressure, all outputs come straight from flops.
module set_bank_lockable #(
    parameter int                      NFLAGS     = 7,
    parameter int                      TW         = 4,
    parameter logic [NFLAGS-1:0]       RST_FLAGS  = 7'b0111111,
    parameter bit                      LOCK_EN    = 1'b1,
    parameter logic [NFLAGS+TW-1:0]    KEY        = {(NFLAGS+TW){1'b1}},
    parameter int                      UNLOCK_CYC = 64
) (
    input  logic                   CLK,
    input  logic                   POR,
    input  logic                   BACT,
    input  logic [NFLAGS+TW:1]     A,
    input  logic                   SetCSWR,
    input  logic                   KeyCSWR,
    input  logic                   SlowStart,
    output logic [NFLAGS-1:0]      Flags,
    output logic [TW-1:0]          SlowTimeout,
    output logic                   Locked,
    output logic                   TimeoutExp
);
    localparam int WW = (UNLOCK_CYC > 1) ? $clog2(UNLOCK_CYC) : 1;

    logic              set_wr_q, set_wr_d, set_prev_q, set_prev_d;
    logic              key_wr_q, key_wr_d, key_prev_q, key_prev_d;
    logic [NFLAGS+TW:1] a_q, a_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [TW-1:0]     to_q, to_d;
    logic              locked_q, locked_d;
    logic [WW-1:0]     win_q, win_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              exp_q, exp_d;
    logic              set_evt, key_evt;

    always_comb begin
        set_wr_d   = BACT & SetCSWR;
        key_wr_d   = BACT & KeyCSWR;
        a_d        = A;
        set_prev_d = set_wr_q;
        key_prev_d = key_wr_q;
        set_evt    = set_wr_q & ~set_prev_q;
        key_evt    = key_wr_q & ~key_prev_q;

        flags_d  = flags_q;
        to_d     = to_q;
        locked_d = locked_q;
        win_d    = win_q;

        if (!locked_q) begin
            if (win_q == '0) locked_d = 1'b1;
            else             win_d    = win_q - WW'(1);
        end
        // Set is judged on the lock state entering this cycle; a same-cycle key then overrides.
        if (set_evt && !locked_q) begin
            flags_d  = a_q[NFLAGS:1];
            to_d     = a_q[NFLAGS+TW:NFLAGS+1];
            locked_d = 1'b1;
            win_d    = '0;
        end
        if (key_evt) begin
            if (a_q == KEY) begin
                locked_d = 1'b0;
                win_d    = WW'(UNLOCK_CYC - 1);
            end else begin
                locked_d = 1'b1;
                win_d    = '0;
            end
        end
        if (!LOCK_EN) begin
            locked_d = 1'b0;
            win_d    = '0;
        end

        run_d = run_q;
        cnt_d = cnt_q;
        exp_d = 1'b0;
        if (SlowStart) begin
            run_d = (to_q != '0);
            cnt_d = to_q;
        end else if (run_q) begin
            if (!BACT) begin
                run_d = 1'b0;
            end else if (cnt_q == TW'(1)) begin
                exp_d = 1'b1;
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (POR) begin
            set_wr_q   <= 1'b0;
            set_prev_q <= 1'b0;
            key_wr_q   <= 1'b0;
            key_prev_q <= 1'b0;
            a_q        <= '0;
            flags_q    <= RST_FLAGS;
            to_q       <= '1;
            locked_q   <= LOCK_EN;
            win_q      <= '0;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            exp_q      <= 1'b0;
        end else begin
            set_wr_q   <= set_wr_d;
            set_prev_q <= set_prev_d;
            key_wr_q   <= key_wr_d;
            key_prev_q <= key_prev_d;
            a_q        <= a_d;
            flags_q    <= flags_d;
            to_q       <= to_d;
            locked_q   <= locked_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            exp_q      <= exp_d;
        end
    end

    assign Flags       = flags_q;
    assign SlowTimeout = to_q;
    assign Locked      = locked_q;
    assign TimeoutExp  = exp_q;
endmodule

// File: tb/tb_set_bank_lockable.sv
// Scoreboard bench for set_bank_lockable: expected register state and timeout pulses are queued as stimulus is driven.
module tb_set_bank_lockable;
    localparam int NF = 7;
    localparam int TW = 4;

    logic          CLK = 1'b0;
    logic          POR = 1'b1;
    logic          BACT = 1'b0;
    logic [NF+TW:1] A = '0;
    logic          SetCSWR = 1'b0;
    logic          KeyCSWR = 1'b0;
    logic          SlowStart = 1'b0;
    logic [NF-1:0] Flags;
    logic [TW-1:0] SlowTimeout;
    logic          Locked;
    logic          TimeoutExp;

    set_bank_lockable dut (
        .CLK(CLK), .POR(POR), .BACT(BACT), .A(A),
        .SetCSWR(SetCSWR), .KeyCSWR(KeyCSWR), .SlowStart(SlowStart),
        .Flags(Flags), .SlowTimeout(SlowTimeout), .Locked(Locked), .TimeoutExp(TimeoutExp)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        string         tag;
        logic [NF-1:0] flags;
        logic [TW-1:0] to;
        logic          locked;
    } state_t;

    state_t exp_q[$];
    int     pulse_q[$];
    int     pulses_seen = 0;

    // Spec-level model of the register state
    logic [NF-1:0] m_flags;
    logic [TW-1:0] m_to;
    logic          m_locked;

    always @(negedge CLK) begin
        if (TimeoutExp) begin
            pulses_seen++;
            if (pulse_q.size() == 0) check("exp_unexpected", 32'd1, 32'd0);
            else                     check("exp_cycle", cyc, pulse_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_state(input string tag);
        state_t s;
        s.tag = tag; s.flags = m_flags; s.to = m_to; s.locked = m_locked;
        exp_q.push_back(s);
    endtask

    task automatic check_state();
        state_t s;
        @(negedge CLK);
        s = exp_q.pop_front();
        check({s.tag, "_flags"},  Flags,       s.flags);
        check({s.tag, "_to"},     SlowTimeout, s.to);
        check({s.tag, "_locked"}, Locked,      s.locked);
    endtask

    task automatic bus_write(input bit is_key, input bit is_set, input logic [NF+TW:1] addr);
        BACT = 1'b1; KeyCSWR = is_key; SetCSWR = is_set; A = addr;
        tick();
        BACT = 1'b0; KeyCSWR = 1'b0; SetCSWR = 1'b0;
        tick();
        tick();
    endtask

    task automatic model_set(input logic [NF+TW:1] addr);
        if (!m_locked) begin
            m_flags  = addr[NF:1];
            m_to     = addr[NF+TW:NF+1];
            m_locked = 1'b1;
        end
    endtask

    task automatic do_key(input string tag, input logic [NF+TW:1] addr);
        bus_write(1'b1, 1'b0, addr);
        m_locked = (addr != 11'h7FF);
        expect_state(tag);
        check_state();
    endtask

    task automatic do_set(input string tag, input logic [NF+TW:1] addr);
        bus_write(1'b0, 1'b1, addr);
        model_set(addr);
        expect_state(tag);
        check_state();
    endtask

    initial begin
        int p0;
        m_flags = 7'h3F; m_to = 4'hF; m_locked = 1'b1;
        POR = 1'b1;
        tick(); tick();
        expect_state("reset");
        check_state();
        check("reset_exp", TimeoutExp, 1'b0);
        POR = 1'b0;
        tick();

        do_set("locked_set", 11'h2A5);
        do_key("key_ok", 11'h7FF);
        do_set("unlocked_set", 11'h2A5);
        do_key("wrong_key", 11'h7FE);

        // Window expiry: open for UNLOCK_CYC cycles after the key takes effect
        do_key("win_key", 11'h7FF);
        repeat (62) tick();
        expect_state("win_last_open");
        check_state();
        tick();
        m_locked = 1'b1;
        expect_state("win_closed");
        check_state();
        do_set("win_late_set", 11'h155);

        // Set held with BACT high: only the first value commits
        do_key("hold_key", 11'h7FF);
        BACT = 1'b1; SetCSWR = 1'b1; A = 11'h1C3;
        repeat (3) tick();
        A = 11'h03C;
        repeat (7) tick();
        BACT = 1'b0; SetCSWR = 1'b0;
        tick(); tick();
        model_set(11'h1C3);
        expect_state("held_set");
        check_state();

        // Set and key together while locked: set dropped, then unlocked
        BACT = 1'b1; SetCSWR = 1'b1; KeyCSWR = 1'b1; A = 11'h7FF;
        tick();
        BACT = 1'b0; SetCSWR = 1'b0; KeyCSWR = 1'b0;
        tick(); tick();
        m_locked = 1'b0;
        expect_state("set_key_same");
        check_state();
        do_key("relock_wrong", 11'h7FE);

        // Timeout of 3 with BACT held: single pulse three cycles after SlowStart
        do_key("to3_key", 11'h7FF);
        do_set("to3_set", {4'd3, 7'h11});
        p0 = pulses_seen;
        pulse_q.push_back(cyc + 4);
        SlowStart = 1'b1; BACT = 1'b1;
        tick();
        SlowStart = 1'b0;
        repeat (8) tick();
        BACT = 1'b0;
        tick();
        check("to3_pulses", pulses_seen - p0, 1);

        // BACT dropped after two cycles: silent abort
        p0 = pulses_seen;
        SlowStart = 1'b1; BACT = 1'b1;
        tick();
        SlowStart = 1'b0;
        tick();
        BACT = 1'b0;
        repeat (6) tick();
        BACT = 1'b1;
        repeat (6) tick();
        BACT = 1'b0;
        tick();
        check("abort_pulses", pulses_seen - p0, 0);

        // Timeout of zero disables the engine
        do_key("to0_key", 11'h7FF);
        do_set("to0_set", {4'd0, 7'h55});
        p0 = pulses_seen;
        SlowStart = 1'b1; BACT = 1'b1;
        tick();
        SlowStart = 1'b0;
        repeat (20) tick();
        BACT = 1'b0;
        tick();
        check("to0_pulses", pulses_seen - p0, 0);

        // POR in the middle of a count and an open window
        do_key("por_key1", 11'h7FF);
        do_set("por_set", {4'd5, 7'h0F});
        do_key("por_key2", 11'h7FF);
        p0 = pulses_seen;
        SlowStart = 1'b1; BACT = 1'b1;
        tick();
        SlowStart = 1'b0;
        tick();
        POR = 1'b1;
        tick();
        POR = 1'b0;
        m_flags = 7'h3F; m_to = 4'hF; m_locked = 1'b1;
        expect_state("por_mid");
        check_state();
        repeat (10) tick();
        BACT = 1'b0;
        tick();
        check("por_pulses", pulses_seen - p0, 0);
        do_set("post_por_set", 11'h2A5);

        check("exp_missing", pulse_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
